// File: rtl/encryptor_seq_pkg.sv
// Shared types, default sizing and width helpers for the encryptor sequencer.
package encryptor_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;

    // Counter/pointer width for a range of n values (never narrower than 1 bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_REGISTER_SIZE = 32;
    localparam int DEF_IN_BLOCKS     = 128;
    localparam int DEF_CONST_BLOCKS  = 256;
    localparam int DEF_RED_BLOCKS    = 128;
    localparam int DEF_NUM_REQ       = 2;
    localparam int DEF_READ_LATENCY  = 2;
    localparam int DEF_TIMEOUT       = 65536;

    localparam int EXP_ADDR_W   = cnt_w(DEF_IN_BLOCKS);
    localparam int CONST_ADDR_W = cnt_w(DEF_CONST_BLOCKS);
    localparam int REQ_ID_W     = cnt_w(DEF_NUM_REQ);
    localparam int TIMEOUT_W    = cnt_w(DEF_TIMEOUT);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches the request vector starting just after the last grant.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req_in,
    input  logic [ID_W-1:0]    last_grant_in,
    output logic [NUM_REQ-1:0] grant_out,
    output logic [ID_W-1:0]    grant_id_out
);

    logic [ID_W-1:0] sel;
    logic            found;

    always_comb begin
        grant_out    = '0;
        grant_id_out = '0;
        found        = 1'b0;
        sel          = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            sel = ID_W'((int'(last_grant_in) + i) % NUM_REQ);
            if (!found && req_in[sel]) begin
                found          = 1'b1;
                grant_out[sel] = 1'b1;
                grant_id_out   = sel;
            end
        end
    end

endmodule

// File: rtl/encryptor_sequencer.sv
// Time-shares one candidate_encryptor between NUM_REQ requesters: arbitration,
// exponentiator streaming, constant-ROM pointer stepping and completion detection.
module encryptor_sequencer
    import encryptor_seq_pkg::*;
#(
    parameter int REGISTER_SIZE = DEF_REGISTER_SIZE,
    parameter int IN_BLOCKS     = DEF_IN_BLOCKS,
    parameter int CONST_BLOCKS  = DEF_CONST_BLOCKS,
    parameter int RED_BLOCKS    = DEF_RED_BLOCKS,
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int READ_LATENCY  = DEF_READ_LATENCY,
    parameter int TIMEOUT       = DEF_TIMEOUT,
    localparam int EXP_W        = cnt_w(IN_BLOCKS),
    localparam int CA_W         = cnt_w(CONST_BLOCKS),
    localparam int ID_W         = cnt_w(NUM_REQ)
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [NUM_REQ-1:0] req_valid_in,
    input  logic [NUM_REQ-1:0] req_candidate_in,
    output logic [NUM_REQ-1:0] req_ready_out,
    output logic [EXP_W-1:0]   exp_addr_out,
    output logic               enc_valid_out,
    output logic               enc_candidate_out,
    input  logic               enc_consumed_k_in,
    input  logic               enc_consumed_n_squared_in,
    output logic [CA_W-1:0]    k_addr_out,
    output logic [CA_W-1:0]    n_squared_addr_out,
    input  logic               enc_valid_in,
    output logic               out_last_out,
    output logic               done_out,
    output logic [ID_W-1:0]    done_id_out,
    output logic               busy_out,
    output logic               timeout_out
);

    localparam int CNT_W = cnt_w((IN_BLOCKS > RED_BLOCKS) ? IN_BLOCKS : RED_BLOCKS);
    localparam int WD_W  = cnt_w(TIMEOUT);

    if (REGISTER_SIZE < 1 || READ_LATENCY < 1 || TIMEOUT < 1) begin : g_param_check
        $error("encryptor_sequencer: REGISTER_SIZE, READ_LATENCY and TIMEOUT must be positive");
    end

    seq_state_e              state_q, state_d;
    logic                    cand_q, cand_d;
    logic [ID_W-1:0]         id_q, id_d;
    logic [ID_W-1:0]         last_grant_q, last_grant_d;
    logic [EXP_W-1:0]        exp_addr_q, exp_addr_d;
    logic [CA_W-1:0]         k_addr_q, k_addr_d;
    logic [CA_W-1:0]         n_addr_q, n_addr_d;
    logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic [READ_LATENCY-1:0] sr_q, sr_d;
    logic                    timeout_q, timeout_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               handshake;
    logic               active;
    logic               last_blk;
    logic [CNT_W-1:0]   target_m1;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_in        (req_valid_in),
        .last_grant_in (last_grant_q),
        .grant_out     (grant),
        .grant_id_out  (grant_id)
    );

    // Grants are withheld while reset is asserted so no handshake can slip through it.
    assign req_ready_out = (state_q == ST_IDLE && rst_n_in) ? grant : '0;
    assign handshake     = |(req_valid_in & req_ready_out);
    assign active        = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign target_m1     = cand_q ? CNT_W'(RED_BLOCKS - 1) : CNT_W'(IN_BLOCKS - 1);
    assign last_blk      = active && enc_valid_in && (out_cnt_q == target_m1);

    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        exp_addr_d   = exp_addr_q;
        k_addr_d     = k_addr_q;
        n_addr_d     = n_addr_q;
        out_cnt_d    = out_cnt_q;
        wd_d         = wd_q;
        timeout_d    = 1'b0;
        sr_d         = sr_q << 1;
        sr_d[0]      = (state_q == ST_ISSUE);

        if (active) begin
            if (enc_consumed_k_in) begin
                k_addr_d = (k_addr_q == CA_W'(CONST_BLOCKS - 1)) ? '0 : k_addr_q + 1'b1;
            end
            if (enc_consumed_n_squared_in) begin
                n_addr_d = (n_addr_q == CA_W'(CONST_BLOCKS - 1)) ? '0 : n_addr_q + 1'b1;
            end
            if (enc_valid_in && !last_blk) begin
                out_cnt_d = out_cnt_q + 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    cand_d     = req_candidate_in[grant_id];
                    id_d       = grant_id;
                    exp_addr_d = '0;
                    k_addr_d   = '0;
                    n_addr_d   = '0;
                    out_cnt_d  = '0;
                    wd_d       = '0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Passthrough results can complete the job before issuing finishes.
                if (last_blk) begin
                    state_d = ST_DONE;
                end else if (exp_addr_q == EXP_W'(IN_BLOCKS - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    exp_addr_d = exp_addr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (last_blk) begin
                    state_d = ST_DONE;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    timeout_d    = 1'b1;
                    sr_d         = '0;
                    last_grant_d = id_q;
                    state_d      = ST_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_DONE: begin
                last_grant_d = id_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_IDLE;
            cand_q       <= 1'b0;
            id_q         <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            exp_addr_q   <= '0;
            k_addr_q     <= '0;
            n_addr_q     <= '0;
            out_cnt_q    <= '0;
            wd_q         <= '0;
            sr_q         <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            exp_addr_q   <= exp_addr_d;
            k_addr_q     <= k_addr_d;
            n_addr_q     <= n_addr_d;
            out_cnt_q    <= out_cnt_d;
            wd_q         <= wd_d;
            sr_q         <= sr_d;
            timeout_q    <= timeout_d;
        end
    end

    assign exp_addr_out       = exp_addr_q;
    assign enc_valid_out      = sr_q[READ_LATENCY-1];
    assign enc_candidate_out  = cand_q;
    assign k_addr_out         = k_addr_q;
    assign n_squared_addr_out = n_addr_q;
    assign out_last_out       = last_blk;
    assign done_out           = (state_q == ST_DONE);
    assign done_id_out        = (state_q == ST_DONE) ? id_q : '0;
    assign busy_out           = (state_q != ST_IDLE);
    assign timeout_out        = timeout_q;

endmodule

// File: tb/tb_encryptor_sequencer.sv
// Bench for encryptor_sequencer: grant table, job scoreboard and multi-cycle corner cases.
module tb_encryptor_sequencer;
    import encryptor_seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n;
    logic [1:0]              req_valid, req_cand, req_ready;
    logic [EXP_ADDR_W-1:0]   exp_addr;
    logic                    enc_valid_o, enc_cand_o, cons_k, cons_n, enc_valid_i;
    logic [CONST_ADDR_W-1:0] k_addr, n_addr;
    logic                    out_last, done, busy, timeout_o;
    logic [REQ_ID_W-1:0]     done_id;

    logic [1:0]              wreq_valid, wreq_cand, w_ready;
    logic [EXP_ADDR_W-1:0]   w_exp_addr;
    logic                    w_enc_valid_o, w_enc_cand_o, w_last, w_done, w_busy, w_timeout;
    logic [CONST_ADDR_W-1:0] w_k_addr, w_n_addr;
    logic [REQ_ID_W-1:0]     w_done_id;

    encryptor_sequencer dut (
        .clk_in(clk), .rst_n_in(rst_n), .req_valid_in(req_valid), .req_candidate_in(req_cand),
        .req_ready_out(req_ready), .exp_addr_out(exp_addr), .enc_valid_out(enc_valid_o),
        .enc_candidate_out(enc_cand_o), .enc_consumed_k_in(cons_k), .enc_consumed_n_squared_in(cons_n),
        .k_addr_out(k_addr), .n_squared_addr_out(n_addr), .enc_valid_in(enc_valid_i),
        .out_last_out(out_last), .done_out(done), .done_id_out(done_id), .busy_out(busy),
        .timeout_out(timeout_o)
    );

    encryptor_sequencer #(.TIMEOUT(64)) dut_wd (
        .clk_in(clk), .rst_n_in(rst_n), .req_valid_in(wreq_valid), .req_candidate_in(wreq_cand),
        .req_ready_out(w_ready), .exp_addr_out(w_exp_addr), .enc_valid_out(w_enc_valid_o),
        .enc_candidate_out(w_enc_cand_o), .enc_consumed_k_in(1'b0), .enc_consumed_n_squared_in(1'b0),
        .k_addr_out(w_k_addr), .n_squared_addr_out(w_n_addr), .enc_valid_in(1'b0),
        .out_last_out(w_last), .done_out(w_done), .done_id_out(w_done_id), .busy_out(w_busy),
        .timeout_out(w_timeout)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint outs_main();
        return longint'({req_ready, exp_addr, enc_valid_o, enc_cand_o, k_addr, n_addr,
                         out_last, done, done_id, busy, timeout_o});
    endfunction

    function automatic longint outs_wd();
        return longint'({w_ready, w_exp_addr, w_enc_valid_o, w_enc_cand_o, w_k_addr, w_n_addr,
                         w_last, w_done, w_done_id, w_busy, w_timeout});
    endfunction

    // Encryptor model: echoes valid one cycle later, optionally with 5 trailing extras.
    logic echo_en, extra_mode, man_ev;
    logic ev_q = 1'b0;
    int   extra_left = 0;
    always @(posedge clk) begin
        ev_q <= enc_valid_o;
        if (out_last && extra_mode) extra_left <= 5;
        else if (extra_left > 0)    extra_left <= extra_left - 1;
    end
    assign enc_valid_i = echo_en ? (ev_q || (extra_left > 0)) : man_ev;

    typedef struct {
        int   id;
        logic cand;
        int   t;
        bit   win;
    } job_t;
    job_t sb[$];
    int   gids[$];

    int   ev_cnt, ev_first, ev_last, ol_cnt, ol_total, last_cyc, cand_bad, viol;
    int   done_cnt, wdone_cnt, wto_cnt, wto_cyc;
    logic cur_cand;
    initial begin
        ev_cnt = 0; ev_first = -1; ev_last = -1; ol_cnt = 0; ol_total = 0; last_cyc = -1;
        cand_bad = 0; viol = 0; done_cnt = 0; wdone_cnt = 0; wto_cnt = 0; wto_cyc = -1;
        cur_cand = 1'b0;
    end

    always @(negedge clk) begin
        logic [1:0] hs;
        job_t       it;
        if (rst_n) begin
            hs = req_valid & req_ready;
            if (hs != 2'b00) begin
                it.id    = hs[1] ? 1 : 0;
                it.cand  = req_cand[it.id];
                it.t     = cyc;
                it.win   = echo_en;
                cur_cand = it.cand;
                sb.push_back(it);
                gids.push_back(it.id);
                ev_cnt = 0; ev_first = -1; ev_last = -1; ol_cnt = 0; cand_bad = 0;
            end
            if (enc_valid_o) begin
                ev_cnt++;
                if (ev_first < 0) ev_first = cyc;
                ev_last = cyc;
                if (enc_cand_o !== cur_cand) cand_bad++;
            end
            if (out_last) begin
                ol_cnt++;
                ol_total++;
                last_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    it = sb.pop_front();
                    check("done_id", done_id, it.id);
                    check("done_after_last", cyc, last_cyc + 1);
                    check("out_last_count", ol_cnt, 1);
                    check("cand_hold", cand_bad, 0);
                    if (it.win) begin
                        check("ev_first", ev_first, it.t + 3);
                        check("ev_last", ev_last, it.t + 130);
                        check("ev_count", ev_cnt, 128);
                        check("done_cycle", cyc, it.t + 132);
                    end
                end
            end
            if ((busy && req_ready != 2'b00) || $countones(req_ready) > 1) viol++;
            if (w_done) wdone_cnt++;
            if (w_timeout) begin
                wto_cnt++;
                wto_cyc = cyc;
            end
        end
    end

    task automatic wait_done(input string name, input int target);
        for (int i = 0; i < 600 && done_cnt < target; i++) @(posedge clk);
        check(name, done_cnt, target);
    endtask

    typedef struct {
        logic [1:0] valid;
        logic [1:0] cand;
        logic [1:0] ready;
    } vec_t;
    vec_t tbl[7];

    initial begin
        int dbase, olbase, bad, wt;
        tbl[0] = '{2'b01, 2'b00, 2'b01};
        tbl[1] = '{2'b11, 2'b10, 2'b10};
        tbl[2] = '{2'b11, 2'b01, 2'b01};
        tbl[3] = '{2'b11, 2'b00, 2'b10};
        tbl[4] = '{2'b10, 2'b10, 2'b10};
        tbl[5] = '{2'b11, 2'b11, 2'b01};
        tbl[6] = '{2'b10, 2'b00, 2'b10};

        rst_n = 1'b0; req_valid = 2'b00; req_cand = 2'b00; cons_k = 1'b0; cons_n = 1'b0;
        echo_en = 1'b1; extra_mode = 1'b0; man_ev = 1'b0; wreq_valid = 2'b00; wreq_cand = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_outs", outs_main(), 0);
        check("reset_outs_wd", outs_wd(), 0);

        // Grant table, one job per row with the echo model.
        for (int v = 0; v < 7; v++) begin
            dbase = done_cnt;
            @(posedge clk); #1;
            req_valid = tbl[v].valid;
            req_cand  = tbl[v].cand;
            @(negedge clk);
            check($sformatf("tbl_grant%0d", v), req_ready, tbl[v].ready);
            @(posedge clk); #1;
            req_valid = 2'b00;
            wait_done($sformatf("tbl_done%0d", v), dbase + 1);
        end

        // Continuous requests from both: strict alternation.
        gids.delete();
        dbase = done_cnt;
        @(posedge clk); #1;
        req_valid = 2'b11;
        req_cand  = 2'b01;
        for (int i = 0; i < 1000 && gids.size() < 4; i++) @(posedge clk);
        #1 req_valid = 2'b00;
        check("cont_grant_count", gids.size(), 4);
        if (gids.size() >= 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("cont_grant%0d", i), gids[i], i % 2);
        end
        wait_done("cont_done", dbase + 4);

        // Reset in the middle of ISSUE.
        @(posedge clk); #1;
        req_valid = 2'b01;
        req_cand  = 2'b01;
        @(negedge clk);
        check("rst_job_grant", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_outs", outs_main(), 0);
        check("abort_pending", sb.size(), 1);
        if (sb.size() > 0) void'(sb.pop_front());
        dbase = done_cnt;
        repeat (5) @(posedge clk);
        check("abort_no_done", done_cnt, dbase);
        #1;
        req_valid = 2'b01;
        req_cand  = 2'b00;
        @(negedge clk);
        check("restart_grant", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        check("restart_addr0", exp_addr, 0);
        check("restart_busy", busy, 1);
        @(negedge clk);
        check("restart_addr1", exp_addr, 1);
        wait_done("restart_done", dbase + 1);

        // Candidate 1 with 300 k / 300 n_squared consume strobes, then 128 results.
        echo_en = 1'b0;
        dbase = done_cnt;
        @(posedge clk); #1;
        req_valid = 2'b10;
        req_cand  = 2'b10;
        @(negedge clk);
        check("ptr_grant", req_ready, 2'b10);
        @(posedge clk); #1;
        req_valid = 2'b00;
        for (int i = 0; i < 320; i++) begin
            @(posedge clk); #1;
            cons_k = (i < 300);
            cons_n = (i >= 20);
            @(negedge clk);
            if (i == 256) begin
                check("k_wrap", k_addr, 0);
                check("n_mid", n_addr, 236);
            end
        end
        @(posedge clk); #1;
        cons_k = 1'b0;
        cons_n = 1'b0;
        @(negedge clk);
        check("k_final", k_addr, 44);
        check("n_final", n_addr, 44);
        check("ptr_busy", busy, 1);
        bad = 0;
        for (int j = 0; j < 128; j++) begin
            @(posedge clk); #1;
            man_ev = 1'b1;
            @(negedge clk);
            if (out_last !== (j == 127)) bad++;
        end
        @(posedge clk); #1;
        man_ev = 1'b0;
        check("manual_out_last", bad, 0);
        wait_done("ptr_done", dbase + 1);
        echo_en = 1'b1;

        // Five extra results after the last block.
        extra_mode = 1'b1;
        dbase  = done_cnt;
        olbase = ol_total;
        @(posedge clk); #1;
        req_valid = 2'b01;
        req_cand  = 2'b00;
        @(negedge clk);
        check("extra_grant", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_done("extra_done", dbase + 1);
        repeat (10) @(posedge clk);
        check("extra_done_once", done_cnt, dbase + 1);
        check("extra_last_once", ol_total, olbase + 1);
        check("extra_idle", busy, 0);
        extra_mode = 1'b0;

        // Watchdog instance: no results ever return.
        @(posedge clk); #1;
        wreq_valid = 2'b01;
        wreq_cand  = 2'b00;
        @(negedge clk);
        check("wd_grant", w_ready, 2'b01);
        wt = cyc;
        @(posedge clk); #1;
        wreq_valid = 2'b00;
        for (int i = 0; i < 400 && wto_cnt == 0; i++) @(posedge clk);
        check("wd_timeout_seen", wto_cnt, 1);
        check("wd_timeout_cycle", wto_cyc, wt + 193);
        repeat (5) @(posedge clk);
        check("wd_timeout_once", wto_cnt, 1);
        check("wd_no_done", wdone_cnt, 0);
        check("wd_idle", w_busy, 0);
        #1;
        wreq_valid = 2'b11;
        @(negedge clk);
        check("wd_next_grant", w_ready, 2'b10);
        @(posedge clk); #1;
        wreq_valid = 2'b00;
        @(negedge clk);
        check("wd_next_busy", w_busy, 1);

        check("no_grant_while_busy", viol, 0);
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "bench time limit reached");
    end

endmodule

// File: doc/encryptor_sequencer.md
# encryptor_sequencer

Controller that time-shares one `candidate_encryptor` datapath between `NUM_REQ` ballot requesters. It arbitrates vote requests round-robin and streams the exponentiator blocks for the granted vote out of BRAM. It steps the `k` and `n_squared` constant-ROM pointers on the encryptor's consume strobes and counts result blocks to detect job completion. It sits between the ballot-intake logic and the encryptor/accumulator chain.

## Interface
- `REGISTER_SIZE`, 32: datapath block width; informational, no data passes through this block.
- `IN_BLOCKS`, 128: exponentiator blocks streamed per vote.
- `CONST_BLOCKS`, 256: depth of the `k` and `n_squared` ROMs.
- `RED_BLOCKS`, 128: output blocks expected when candidate = 1 (reducer output).
- `NUM_REQ`, 2: number of requesters.
- `READ_LATENCY`, 2: exponentiator BRAM read latency in cycles.
- `TIMEOUT`, 65536: maximum DRAIN cycles before abort.

Ports (name, direction, width, meaning):
- `clk_in` in 1: single clock.
- `rst_n_in` in 1: reset, synchronous, active-low.
- `req_valid_in` in NUM_REQ: per-requester vote request.
- `req_candidate_in` in NUM_REQ: vote bit, sampled at grant.
- `req_ready_out` out NUM_REQ: one-hot grant; handshake completes on valid&&ready.
- `exp_addr_out` out clog2(IN_BLOCKS): exponentiator BRAM read address.
- `enc_valid_out` out 1: drives the encryptor `valid_in`.
- `enc_candidate_out` out 1: drives the encryptor `candidate_in`.
- `enc_consumed_k_in` in 1: encryptor `consumed_k_out`.
- `enc_consumed_n_squared_in` in 1: encryptor `consumed_n_squared_out`.
- `k_addr_out` out clog2(CONST_BLOCKS): `k` ROM address.
- `n_squared_addr_out` out clog2(CONST_BLOCKS): `n_squared` ROM address.
- `enc_valid_in` in 1: encryptor `valid_out`.
- `out_last_out` out 1: high with the final result block.
- `done_out` out 1: one-cycle completion pulse.
- `done_id_out` out clog2(NUM_REQ): requester index of the completed job.
- `busy_out` out 1: high in any state other than IDLE.
- `timeout_out` out 1: one-cycle pulse on watchdog abort.

## Operation
- States: IDLE → ISSUE → DRAIN → DONE → IDLE.
- **IDLE**
  - Round-robin arbitration over `req_valid_in`, starting from `last_grant+1`.
  - The winner's `req_ready_out` bit is asserted combinationally in the same cycle.
  - On handshake: latch the candidate bit and requester id, clear all counters and both ROM pointers, go to ISSUE.
- **ISSUE**
  - `exp_addr_out` steps 0..IN_BLOCKS-1, one per cycle.
  - An issue strobe enters a READ_LATENCY-deep shift register. Its output is `enc_valid_out`, so `enc_valid_out` is contiguous for exactly IN_BLOCKS cycles.
  - `enc_candidate_out` holds the latched bit for the whole job.
  - After the last address is issued, go to DRAIN. Any remaining strobes still flush out of the shift register.
- **ROM pointers** (active in ISSUE and DRAIN)
  - `k_addr_out` increments on each `enc_consumed_k_in`.
  - `n_squared_addr_out` increments on each `enc_consumed_n_squared_in`.
  - Each wraps from CONST_BLOCKS-1 to 0.
  - Both strobes in the same cycle advance both pointers.
- **Output count** (active in ISSUE and DRAIN)
  - Counts `enc_valid_in`. Target is IN_BLOCKS for candidate 0 and RED_BLOCKS for candidate 1.
  - `out_last_out` is asserted in the cycle `enc_valid_in` is high and count = target-1.
  - That event moves the FSM to DONE. For candidate 0 the passthrough blocks can arrive during ISSUE, so the transition may come directly from ISSUE.
  - `enc_valid_in` beyond the target is ignored.
- **DONE**: `done_out`=1 and `done_id_out` valid for one cycle; `last_grant` is updated; return to IDLE.
- **Watchdog**
  - Counts cycles spent in DRAIN. On reaching TIMEOUT: pulse `timeout_out`, flush the shift register, return to IDLE.
  - No `done_out` is issued, and `last_grant` is still advanced.

## Timing
- **Reset**: while `rst_n_in`=0 at a clock edge:
  - All outputs go to 0, state to IDLE, `last_grant` to NUM_REQ-1.
  - Reset applied mid-job abandons the job with no `done_out`.
- **Latency**
  - Handshake at cycle t: first `exp_addr_out`=0 at t+1; first `enc_valid_out` at t+1+READ_LATENCY.
  - Last `enc_valid_out` at t+IN_BLOCKS+READ_LATENCY.
  - `done_out` appears one cycle after `out_last_out`.
- **Grants**: at most one grant per job; no grant is issued while `busy_out`=1.
- **Requester drop**: a requester deasserting valid before its grant is legal; arbitration simply skips it.
- **Simultaneous requests**: all-valid requests alternate strictly 0,1,0,1,...

## Structure
- Package `encryptor_seq_pkg`:
  - state enum.
  - `localparam` widths for exponentiator address, constant address and requester id.
  - TIMEOUT counter width.
- One sub-module: `rr_arbiter` (request vector, last-grant pointer → one-hot grant).
- Everything else inline: FSM, address counters, latency shift register, output counter, watchdog.

## Test plan
- Single request, requester 0, candidate 0; encryptor model echoes valid 1 cycle later → `enc_valid_out` high for cycles t+3..t+130 (READ_LATENCY 2), exactly 128 `enc_valid_in`, `out_last_out` on the 128th, `done_out` next cycle with `done_id_out`=0.
- Candidate 1, model issues 300 `enc_consumed_k_in` and 300 `enc_consumed_n_squared_in` pulses (some in the same cycle) → both pointers end at 300 mod 256 = 44; `done_out` after the 128th result block.
- Both requesters valid continuously for 4 jobs → grants 0,1,0,1; no second grant while `busy_out`=1.
- Model never returns results, TIMEOUT=64 → `timeout_out` pulses once, 64 cycles after DRAIN is entered; no `done_out`; next request is accepted.
- `rst_n_in` low for one cycle mid-ISSUE → all outputs 0 on the next cycle; FSM in IDLE; a fresh request restarts from `exp_addr_out`=0.
- Model returns 5 extra `enc_valid_in` after `out_last_out` → extras ignored; `done_out` pulses exactly once.
